// File: rtl/axi4_write_slave.sv
// AXI4 write-only slave backed by a word-addressed memory, INCR bursts only.
// Errors are reported through BRESP; a registered debug port reads the memory.
module axi4_write_slave #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MEMORY_DEPTH = 1024
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [ADDR_WIDTH-1:0]           AWADDR,
    input  logic [7:0]                      AWLEN,
    input  logic [2:0]                      AWSIZE,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [DATA_WIDTH-1:0]           WDATA,
    input  logic                            WLAST,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [$clog2(MEMORY_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]           dbg_rdata
);

    localparam int unsigned BYTE_LOG   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W      = $clog2(MEMORY_DEPTH);
    localparam int unsigned PAGE_WORDS = 4096 >> BYTE_LOG;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        start_q;
    logic [7:0]              len_q;
    logic [8:0]              count_q;
    logic                    err_q;
    logic                    aw_hs, w_hs, aw_err, wr_en;
    logic [31:0]             aw_word;
    logic [IDX_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   mem [MEMORY_DEPTH];

    always_comb begin
        state_nxt = state;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BRESP     = 2'b00;
        unique case (state)
            IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) state_nxt = DATA;
            end
            DATA: begin
                WREADY = 1'b1;
                if (WVALID && WLAST) state_nxt = RESP;
            end
            RESP: begin
                BVALID = 1'b1;
                BRESP  = err_q ? 2'b10 : 2'b00;
                if (BREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign aw_word = 32'(AWADDR) >> BYTE_LOG;

    // A burst whose last word leaves the start word's 4KB page is rejected up front.
    assign aw_err = (AWSIZE != 3'(BYTE_LOG))
                 || (aw_word + 32'(AWLEN) >= 32'(MEMORY_DEPTH))
                 || ((aw_word & 32'(PAGE_WORDS - 1)) + 32'(AWLEN) >= 32'(PAGE_WORDS));

    assign wr_en  = w_hs && !err_q && (count_q <= {1'b0, len_q}) && !ARESET;
    assign wr_idx = start_q + IDX_W'(count_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            start_q <= '0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (aw_hs) begin
            start_q <= IDX_W'(aw_word);
            len_q   <= AWLEN;
            count_q <= '0;
            err_q   <= aw_err;
        end else if (w_hs) begin
            count_q <= count_q + 9'd1;
            // Overrun and early WLAST both flag the burst; the current beat is still written if in range.
            if ((count_q > {1'b0, len_q}) || (WLAST && (count_q != {1'b0, len_q})))
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_en) mem[wr_idx] <= WDATA;
        dbg_rdata <= mem[dbg_addr];
    end

endmodule

// File: tb/tb_axi4_write_slave.sv
// Randomized self-checking bench for axi4_write_slave against a flat memory
// model that derives responses and writes directly from the burst rules.
module tb_axi4_write_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [15:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [9:0]  dbg_addr = '0;
    logic [31:0] dbg_rdata;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [31:0] mdl [1024];

    axi4_write_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic aw_send(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
        AWADDR = a; AWLEN = l; AWSIZE = s; AWVALID = 1'b1;
        for (int n = 0; n < 50 && !AWREADY; n++) step();
        check("aw_ready", 64'(AWREADY), 64'd1);
        step();
        AWVALID = 1'b0;
        check("aw_drop", 64'(AWREADY), 64'd0);
        check("w_open", 64'(WREADY), 64'd1);
    endtask

    task automatic w_send(input logic [31:0] d, input logic last, input int gap);
        WVALID = 1'b0;
        for (int g = 0; g < gap; g++) step();
        WVALID = 1'b1; WDATA = d; WLAST = last;
        for (int n = 0; n < 50 && !WREADY; n++) step();
        check("w_ready", 64'(WREADY), 64'd1);
        step();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic dbg_check(input int idx, input string tag);
        dbg_addr = 10'(idx);
        step();
        check(tag, 64'(dbg_rdata), 64'(mdl[idx]));
    endtask

    // base != 0 gives data base+i, otherwise random beats
    task automatic do_burst(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                            input int nbeats, input int stall, input logic [31:0] base);
        int          w;
        int          last_byte;
        bit          aerr;
        logic [1:0]  exp_resp;
        logic [31:0] d;
        w         = int'(a) / 4;
        last_byte = (int'(a) & ~3) + (int'(l) + 1) * 4 - 1;
        aerr      = (s != 3'd2) || (w + int'(l) > 1023) || ((int'(a) / 4096) != (last_byte / 4096));
        exp_resp  = (aerr || nbeats != int'(l) + 1) ? 2'b10 : 2'b00;
        aw_send(a, l, s);
        for (int i = 0; i < nbeats; i++) begin
            d = (base != 0) ? base + 32'(i) : $urandom;
            w_send(d, i == nbeats - 1, int'($urandom_range(0, 2)));
            if (!aerr && i <= int'(l)) mdl[w + i] = d;
        end
        check("b_latency", 64'(BVALID), 64'd1);
        check("bresp", 64'(BRESP), 64'(exp_resp));
        if (stall > 0) AWVALID = 1'b1;
        for (int k = 0; k < stall; k++) begin
            step();
            check("b_hold_valid", 64'(BVALID), 64'd1);
            check("b_hold_resp", 64'(BRESP), 64'(exp_resp));
            check("aw_stall", 64'(AWREADY), 64'd0);
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check("b_done", 64'(BVALID), 64'd0);
        check("aw_reopen", 64'(AWREADY), 64'd1);
        AWVALID = 1'b0;
    endtask

    initial begin
        logic [31:0] oldv, newv, d0, d1;
        int          l, nb;
        logic [15:0] a;

        step(); step();
        ARESET = 1'b0;
        check("rst_awready", 64'(AWREADY), 64'd1);
        check("rst_wready", 64'(WREADY), 64'd0);
        check("rst_bvalid", 64'(BVALID), 64'd0);
        check("rst_bresp", 64'(BRESP), 64'd0);

        for (int k = 0; k < 4; k++) do_burst(16'(k * 1024), 8'd255, 3'd2, 256, 0, 32'd0);

        do_burst(16'h0010, 8'd3, 3'd2, 4, 0, 32'hA0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 10'(4 + i);
            step();
            check("incr_word", 64'(dbg_rdata), 64'(32'hA0 + 32'(i)));
        end

        do_burst(16'h0020, 8'd0, 3'd1, 1, 0, 32'd0);
        dbg_check(8, "bad_size_untouched");
        do_burst(16'h0FF8, 8'd3, 3'd2, 4, 1, 32'd0);
        do_burst(16'h0100, 8'd3, 3'd2, 2, 0, 32'd0);
        dbg_check(64, "short_w0");
        dbg_check(65, "short_w1");
        dbg_check(66, "short_untouched");
        do_burst(16'h0200, 8'd2, 3'd2, 3, 5, 32'd0);
        do_burst(16'h0300, 8'd1, 3'd2, 4, 0, 32'd0);
        dbg_check(194, "overrun_discard");

        WVALID = 1'b1; WDATA = 32'hDEADBEEF; WLAST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_wready", 64'(WREADY), 64'd0);
        end
        WVALID = 1'b0; WLAST = 1'b0;

        aw_send(16'h0190, 8'd0, 3'd2);
        dbg_addr = 10'd100;
        oldv = mdl[100];
        newv = $urandom;
        w_send(newv, 1'b1, 0);
        check("dbg_old", 64'(dbg_rdata), 64'(oldv));
        mdl[100] = newv;
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check("dbg_new", 64'(dbg_rdata), 64'(newv));

        for (int r = 0; r < 25; r++) begin
            a  = ($urandom_range(0, 9) < 7) ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom);
            l  = int'($urandom_range(0, 15));
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 18)) : l + 1;
            do_burst(a, 8'(l), ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2, nb,
                     int'($urandom_range(0, 3)), 32'd0);
        end

        aw_send(16'h0200, 8'd3, 3'd2);
        d0 = $urandom; d1 = $urandom;
        w_send(d0, 1'b0, 0);
        w_send(d1, 1'b0, 0);
        mdl[128] = d0; mdl[129] = d1;
        ARESET = 1'b1;
        step();
        ARESET = 1'b0;
        check("mid_rst_awready", 64'(AWREADY), 64'd1);
        check("mid_rst_wready", 64'(WREADY), 64'd0);
        check("mid_rst_bvalid", 64'(BVALID), 64'd0);
        check("mid_rst_bresp", 64'(BRESP), 64'd0);
        for (int i = 128; i < 132; i++) dbg_check(i, "mid_rst_mem");
        do_burst(16'h0040, 8'd1, 3'd2, 2, 0, 32'd0);

        for (int i = 0; i < 1024; i++) dbg_check(i, "sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_write_slave.md
AXI4_WRITE_SLAVE -- requirements
Module: axi4_write_slave

Interface
REQ-001: Parameter DATA_WIDTH, default 32, SHALL set the W-channel data width in bits; legal values are 32 and 64.
REQ-002: Parameter ADDR_WIDTH, default 16, SHALL set the AWADDR width as a byte address.
REQ-003: Parameter MEMORY_DEPTH, default 1024, SHALL set the internal memory size in DATA_WIDTH-bit words.
REQ-004: Clock and reset SHALL be a single clock and a synchronous, active-high reset, both listed first:
  ACLK  in  1  clock; all logic on rising edge
  ARESET  in  1  reset; synchronous, active-high
REQ-005: AW channel SHALL be:
  AWADDR  in  ADDR_WIDTH  burst start byte address
  AWLEN  in  8  beats minus 1
  AWSIZE  in  3  log2 bytes per beat
  AWVALID  in  1  address valid
  AWREADY  out  1  address accept
REQ-006: W channel SHALL be:
  WDATA  in  DATA_WIDTH  write data
  WLAST  in  1  final beat
  WVALID  in  1  data valid
  WREADY  out  1  data accept
REQ-007: B channel SHALL be:
  BRESP  out  2  00 OKAY, 10 SLVERR
  BVALID  out  1  response valid
  BREADY  in  1  response accept
REQ-008: Debug port SHALL be:
  dbg_addr  in  clog2(MEMORY_DEPTH)  word index
  dbg_rdata  out  DATA_WIDTH  memory word, registered

Function
REQ-009: The block SHALL implement a 3-state FSM: IDLE, DATA, RESP. Only INCR bursts are supported; AWBURST is not a port.
REQ-010: In IDLE, AWREADY SHALL be 1. WREADY and BVALID SHALL be 0.
REQ-011: On an AW handshake (AWVALID&&AWREADY), the block SHALL latch AWADDR, AWLEN and AWSIZE. The error flag SHALL be computed, the beat counter cleared, and the FSM moved to DATA. AWREADY SHALL be 0 on the next cycle.
REQ-012: Word index SHALL be AWADDR >> log2(DATA_WIDTH/8); low address bits are ignored.
REQ-013: Error flag SHALL be set at AW handshake if any of the following holds:
  - AWSIZE != log2(DATA_WIDTH/8);
  - start word + AWLEN >= MEMORY_DEPTH;
  - the burst crosses a 4KB boundary.
REQ-014: In DATA, WREADY SHALL be 1 and AWREADY 0. Each W handshake SHALL write WDATA to mem[start+count] only if the error flag is clear and count <= AWLEN; then count SHALL increment.
REQ-015: Beats beyond AWLEN SHALL be accepted and discarded, and SHALL set the error flag.
REQ-016: A W handshake with WLAST=1 SHALL end the burst and move the FSM to RESP.
  - If count at that beat != AWLEN, the error flag SHALL be set.
  - The error flag SHALL NOT suppress writes of beats already taken.
REQ-017: In RESP, BVALID SHALL be 1 and BRESP SHALL be 10 if the error flag is set, else 00. BRESP SHALL be held stable while BVALID=1 && BREADY=0.
REQ-018: A B handshake SHALL return the FSM to IDLE; AWREADY SHALL be 1 on the following cycle, giving a minimum of 1 idle cycle between bursts.
REQ-019: Minimum burst latency SHALL be:
  - AW handshake at cycle 0;
  - first WREADY at cycle 1;
  - BVALID the cycle after the WLAST handshake.
REQ-020: W beats presented in IDLE or RESP SHALL NOT be accepted (WREADY=0). AW presented in DATA or RESP SHALL be stalled (AWREADY=0).
REQ-021: dbg_rdata SHALL equal mem[dbg_addr] one cycle after dbg_addr is applied. A same-cycle write to that address SHALL return the old value.

Reset
REQ-022: While ARESET=1 at a clock edge, the block SHALL:
  - move the FSM to IDLE;
  - drive AWREADY=1 on the following cycle, and WREADY=0, BVALID=0, BRESP=00;
  - clear the beat counter, error flag and latched AW fields.
REQ-023: Reset asserted mid-burst SHALL abandon the burst with no B response. Beats written before reset SHALL remain in memory.
REQ-024: Memory contents and dbg_rdata SHALL NOT be reset.

Verification
REQ-025: AWADDR=0x0010, AWLEN=3, AWSIZE=2, 4 beats 0xA0..0xA3 with WLAST on beat 3 -> mem[4..7]=0xA0..0xA3; BRESP=00; BVALID the cycle after beat 3.
REQ-026: AWSIZE=1 with AWLEN=0 and 1 beat -> BRESP=10; memory unchanged.
REQ-027: AWADDR=0x0FF8, AWLEN=3 (crosses 4KB) -> all 4 beats accepted, none written, BRESP=10.
REQ-028: AWLEN=3 with WLAST on beat 1 -> 2 words written, BRESP=10, FSM returns to IDLE after BREADY.
REQ-029: BREADY held 0 for 5 cycles -> BVALID and BRESP stable throughout; AWVALID asserted meanwhile gets AWREADY=0 until 1 cycle after the B handshake.
REQ-030: ARESET pulsed after 2 of 4 beats -> next cycle AWREADY=1, WREADY=0, BVALID=0; dbg reads show those 2 words written.
